nexys_starship_repair_arb: RTL and testbench

NEXYS_STARSHIP_REPAIR_ARB -- requirements
Module: nexys_starship_repair_arb

---
 rtl/nexys_starship_pkg.sv | 51 +++++
 rtl/nexys_starship_rr_pick.sv | 36 +++
 rtl/nexys_starship_repair_arb.sv | 188 ++++++++++++++++++
 tb/tb_nexys_starship_repair_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nexys_starship_pkg.sv
// -----------------------------------------------------------------------------
// nexys_starship_pkg
// Shared definitions for the starship repair arbiter:
//   - arbiter FSM state encoding (state_t)
//   - room index constants and the combo width
//   - helpers to turn a one-hot room grant into an index or into its combo
// The LOCK state only exists when NEXYS_STARSHIP_REPAIR_LOCKOUT_EN is defined.
// -----------------------------------------------------------------------------
package nexys_starship_pkg;

  localparam int COMBO_W = 4;

  localparam logic [1:0] ROOM_TOP   = 2'd0;
  localparam logic [1:0] ROOM_BTM   = 2'd1;
  localparam logic [1:0] ROOM_LEFT  = 2'd2;
  localparam logic [1:0] ROOM_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CHECK = 2'd2
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
    ,
    ST_LOCK  = 2'd3
`endif
  } state_t;

  // Room index of a one-hot grant; an empty or corrupt grant maps to room 0.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0001: return ROOM_TOP;
      4'b0010: return ROOM_BTM;
      4'b0100: return ROOM_LEFT;
      4'b1000: return ROOM_RIGHT;
      default: return ROOM_TOP;
    endcase
  endfunction

  // Target combo nibble of the room selected by a one-hot grant, 0 if none.
  function automatic logic [COMBO_W-1:0] room_combo(input logic [15:0] combos,
                                                    input logic [3:0]  oh);
    case (oh)
      4'b0001: return combos[3:0];
      4'b0010: return combos[7:4];
      4'b0100: return combos[11:8];
      4'b1000: return combos[15:12];
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/nexys_starship_rr_pick.sv
// -----------------------------------------------------------------------------
// nexys_starship_rr_pick
// Combinational round-robin picker. Searches req starting at room ptr+1
// (wrapping mod 4) and returns the first requester.
// Ports:
//   req    [3:0] in  : room requests
//   ptr    [1:0] in  : index of the last served room
//   onehot [3:0] out : selected room, one-hot (0 when nothing requested)
//   valid        out : at least one request present
// -----------------------------------------------------------------------------
module nexys_starship_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] onehot,
  output logic       valid
);

  logic [1:0] idx_s;
  logic       hit_s;

  // Walk the four rooms in priority order; the first hit latches valid and
  // masks every later candidate.
  always_comb begin
    onehot = 4'b0000;
    valid  = 1'b0;
    idx_s  = ptr;
    hit_s  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx_s         = ptr + 2'(i);
      hit_s         = req[idx_s] & ~valid;
      onehot[idx_s] = onehot[idx_s] | hit_s;
      valid         = valid | hit_s;
    end
  end

endmodule

// File: rtl/nexys_starship_repair_arb.sv
// -----------------------------------------------------------------------------
// nexys_starship_repair_arb
// Arbitrates the shared hex switch console between four room repair requests.
// A granted room enters a combo with submit; a match pulses fixed and releases
// the console, a mismatch pulses err and bumps the saturating miss counter.
// Ports:
//   Clk, Reset (async, active high)
//   play_flag, gameover_ctrl     : game state; arbitration only while playing
//   req[3:0]                     : room requests (top, bottom, left, right)
//   target_combos[15:0]          : expected combo, nibble i for room i
//   hex_combo[3:0], submit, skip : console entry
//   grant[3:0], active_combo[3:0], fixed[3:0], err, miss_cnt[7:0] : registered
// Build option: NEXYS_STARSHIP_REPAIR_LOCKOUT_EN adds a LOCK state that holds
// the grant for LOCK_CYCLES cycles after a wrong combo. Without it a wrong combo
// returns straight to GRANT and LOCK_CYCLES has no effect.
// -----------------------------------------------------------------------------
module nexys_starship_repair_arb
  import nexys_starship_pkg::*;
#(
  parameter int LOCK_CYCLES = 50000000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         play_flag,
  input  logic         gameover_ctrl,
  input  logic [3:0]   req,
  input  logic [15:0]  target_combos,
  input  logic [3:0]   hex_combo,
  input  logic         submit,
  input  logic         skip,
  output logic [3:0]   grant,
  output logic [3:0]   active_combo,
  output logic [3:0]   fixed,
  output logic         err,
  output logic [7:0]   miss_cnt
);

  if (LOCK_CYCLES < 2 || LOCK_CYCLES > 67108864) begin : g_bad_lock_cycles
    $error("LOCK_CYCLES must lie in 2..2^26");
  end

  state_t             state_r, state_next_s;
  logic [3:0]         grant_r, grant_next_s;
  logic [3:0]         active_r, active_next_s;
  logic [3:0]         fixed_r, fixed_next_s;
  logic               err_r, err_next_s;
  logic [7:0]         miss_r, miss_next_s;
  logic [1:0]         ptr_r, ptr_next_s;
  logic [COMBO_W-1:0] combo_r, combo_next_s;
  logic [3:0]         pick_s;
  logic               pick_valid_s;
  logic [1:0]         gidx_s;

`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
  localparam logic [25:0] LOCK_LAST = 26'(LOCK_CYCLES - 1);
  logic [25:0]        lock_cnt_r, lock_cnt_next_s;
`endif

  nexys_starship_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (pick_s),
    .valid  (pick_valid_s)
  );

  assign gidx_s = onehot_to_idx(grant_r);

  // Next-state and next-output logic; the abort path wins over every state.
  always_comb begin
    state_next_s    = state_r;
    grant_next_s    = grant_r;
    ptr_next_s      = ptr_r;
    combo_next_s    = combo_r;
    fixed_next_s    = 4'b0000;
    err_next_s      = 1'b0;
    miss_next_s     = miss_r;
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
    lock_cnt_next_s = lock_cnt_r;
`endif
    if (gameover_ctrl || !play_flag) begin
      state_next_s    = ST_IDLE;
      grant_next_s    = 4'b0000;
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
      lock_cnt_next_s = 26'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            grant_next_s = pick_s;
            state_next_s = ST_GRANT;
          end else begin
            grant_next_s = 4'b0000;
          end
        end
        ST_GRANT: begin
          // submit takes precedence over a simultaneous skip
          if (submit) begin
            combo_next_s = hex_combo;
            state_next_s = ST_CHECK;
          end else if (skip) begin
            ptr_next_s   = gidx_s;
            grant_next_s = 4'b0000;
            state_next_s = ST_IDLE;
          end else if (!req[gidx_s]) begin
            grant_next_s = 4'b0000;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_GRANT;
          end
        end
        ST_CHECK: begin
          if (combo_r == room_combo(target_combos, grant_r)) begin
            fixed_next_s = grant_r;
            ptr_next_s   = gidx_s;
            grant_next_s = 4'b0000;
            state_next_s = ST_IDLE;
          end else begin
            err_next_s = 1'b1;
            if (miss_r != 8'hFF) begin
              miss_next_s = miss_r + 8'd1;
            end else begin
              miss_next_s = miss_r;
            end
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
            lock_cnt_next_s = 26'd0;
            state_next_s    = ST_LOCK;
`else
            state_next_s    = ST_GRANT;
`endif
          end
        end
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
        ST_LOCK: begin
          if (lock_cnt_r == LOCK_LAST) begin
            lock_cnt_next_s = 26'd0;
            state_next_s    = ST_GRANT;
          end else begin
            lock_cnt_next_s = lock_cnt_r + 26'd1;
          end
        end
`endif
        default: begin
          grant_next_s = 4'b0000;
          state_next_s = ST_IDLE;
        end
      endcase
    end
    // Combo display tracks whichever room will own the console next cycle.
    active_next_s = room_combo(target_combos, grant_next_s);
  end

  // State and output registers; ptr starts at 3 so room 0 is served first.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= 4'b0000;
      active_r   <= 4'h0;
      fixed_r    <= 4'b0000;
      err_r      <= 1'b0;
      miss_r     <= 8'd0;
      ptr_r      <= 2'd3;
      combo_r    <= 4'h0;
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
      lock_cnt_r <= 26'd0;
`endif
    end else begin
      state_r    <= state_next_s;
      grant_r    <= grant_next_s;
      active_r   <= active_next_s;
      fixed_r    <= fixed_next_s;
      err_r      <= err_next_s;
      miss_r     <= miss_next_s;
      ptr_r      <= ptr_next_s;
      combo_r    <= combo_next_s;
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
      lock_cnt_r <= lock_cnt_next_s;
`endif
    end
  end

  assign grant        = grant_r;
  assign active_combo = active_r;
  assign fixed        = fixed_r;
  assign err          = err_r;
  assign miss_cnt     = miss_r;

endmodule

// File: tb/tb_nexys_starship_repair_arb.sv
// -----------------------------------------------------------------------------
// tb_nexys_starship_repair_arb
// Directed bench for the repair arbiter with LOCK_CYCLES=8. Expected output
// tuples are queued when a stimulus step is driven and popped for comparison
// once the arbiter should have produced them.
// -----------------------------------------------------------------------------
module tb_nexys_starship_repair_arb;

  logic        Clk;
  logic        Reset;
  logic        play_flag;
  logic        gameover_ctrl;
  logic [3:0]  req;
  logic [15:0] target_combos;
  logic [3:0]  hex_combo;
  logic        submit;
  logic        skip;
  logic [3:0]  grant;
  logic [3:0]  active_combo;
  logic [3:0]  fixed;
  logic        err;
  logic [7:0]  miss_cnt;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] fixed;
    logic       err;
    logic [7:0] miss;
    logic [3:0] active;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  nexys_starship_repair_arb #(.LOCK_CYCLES(8)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .req           (req),
    .target_combos (target_combos),
    .hex_combo     (hex_combo),
    .submit        (submit),
    .skip          (skip),
    .grant         (grant),
    .active_combo  (active_combo),
    .fixed         (fixed),
    .err           (err),
    .miss_cnt      (miss_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input string t, input logic [3:0] g, input logic [3:0] f,
                          input logic e, input logic [7:0] m, input logic [3:0] a);
    exp_t x;
    x.grant = g; x.fixed = f; x.err = e; x.miss = m; x.active = a;
    sb_q.push_back(x);
    tag_q.push_back(t);
  endtask

  task automatic check_pop();
    exp_t  x;
    string t;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x = sb_q.pop_front();
      t = tag_q.pop_front();
      total++;
      assert (grant === x.grant) else begin
        bad++; $error("FAIL %s grant observed=%b expected=%b", t, grant, x.grant);
      end
      total++;
      assert (fixed === x.fixed) else begin
        bad++; $error("FAIL %s fixed observed=%b expected=%b", t, fixed, x.fixed);
      end
      total++;
      assert (err === x.err) else begin
        bad++; $error("FAIL %s err observed=%b expected=%b", t, err, x.err);
      end
      total++;
      assert (miss_cnt === x.miss) else begin
        bad++; $error("FAIL %s miss_cnt observed=%0d expected=%0d", t, miss_cnt, x.miss);
      end
      total++;
      assert (active_combo === x.active) else begin
        bad++; $error("FAIL %s active_combo observed=%h expected=%h", t, active_combo, x.active);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rot_grant[4];
    logic [3:0] rot_combo[4];
    rot_grant[0] = 4'b0010; rot_grant[1] = 4'b0100; rot_grant[2] = 4'b1000; rot_grant[3] = 4'b0001;
    rot_combo[0] = 4'h2;    rot_combo[1] = 4'h3;    rot_combo[2] = 4'h4;    rot_combo[3] = 4'h1;

    Reset = 1'b1; play_flag = 1'b0; gameover_ctrl = 1'b0; req = 4'b0000;
    target_combos = 16'h00A3; hex_combo = 4'h0; submit = 1'b0; skip = 1'b0;
    tick(); tick();
    push_exp("reset", 4'b0000, 4'b0000, 1'b0, 8'd0, 4'h0); check_pop();

    // Room 0 served first, correct combo repairs it, then room 2.
    Reset = 1'b0; play_flag = 1'b1; req = 4'b0101;
    push_exp("t1_grant", 4'b0001, 4'b0000, 1'b0, 8'd0, 4'h3); tick(); check_pop();
    hex_combo = 4'h3; submit = 1'b1;
    push_exp("t1_check", 4'b0001, 4'b0000, 1'b0, 8'd0, 4'h3); tick(); submit = 1'b0; check_pop();
    push_exp("t1_fixed", 4'b0000, 4'b0001, 1'b0, 8'd0, 4'h0); tick(); check_pop();
    push_exp("t1_next", 4'b0100, 4'b0000, 1'b0, 8'd0, 4'h0); tick(); check_pop();

    // Wrong combo for room 2.
    hex_combo = 4'h7; submit = 1'b1; tick(); submit = 1'b0;
    push_exp("t2_err", 4'b0100, 4'b0000, 1'b1, 8'd1, 4'h0); tick(); check_pop();
    hex_combo = 4'h0;
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
    for (int k = 0; k < 8; k++) begin
      submit = 1'b1;
      push_exp("t2_lock", 4'b0100, 4'b0000, 1'b0, 8'd1, 4'h0); tick(); check_pop();
    end
    tick(); submit = 1'b0;
`else
    submit = 1'b1;
    push_exp("t2_retry", 4'b0100, 4'b0000, 1'b0, 8'd1, 4'h0); tick(); submit = 1'b0; check_pop();
`endif
    push_exp("t2_fixed", 4'b0000, 4'b0100, 1'b0, 8'd1, 4'h0); tick(); check_pop();
    push_exp("t2_next", 4'b0001, 4'b0000, 1'b0, 8'd1, 4'h3); tick(); check_pop();

    // submit and skip together: submit wins.
    hex_combo = 4'h3; submit = 1'b1; skip = 1'b1; tick(); submit = 1'b0; skip = 1'b0;
    push_exp("t3_fixed", 4'b0000, 4'b0001, 1'b0, 8'd1, 4'h0); tick(); check_pop();
    push_exp("t3_next", 4'b0100, 4'b0000, 1'b0, 8'd1, 4'h0); tick(); check_pop();

    // Wrong combo then abort via gameover_ctrl; ptr and miss_cnt retained.
    hex_combo = 4'h7; submit = 1'b1; tick(); submit = 1'b0;
    push_exp("t4_err", 4'b0100, 4'b0000, 1'b1, 8'd2, 4'h0); tick(); check_pop();
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
    push_exp("t4_inlock", 4'b0100, 4'b0000, 1'b0, 8'd2, 4'h0); tick(); check_pop();
`endif
    gameover_ctrl = 1'b1;
    push_exp("t4_abort", 4'b0000, 4'b0000, 1'b0, 8'd2, 4'h0); tick(); gameover_ctrl = 1'b0; check_pop();
    push_exp("t4_regrant", 4'b0100, 4'b0000, 1'b0, 8'd2, 4'h0); tick(); check_pop();
    play_flag = 1'b0;
    push_exp("t4_noplay", 4'b0000, 4'b0000, 1'b0, 8'd2, 4'h0); tick(); play_flag = 1'b1; check_pop();
    push_exp("t4_replay", 4'b0100, 4'b0000, 1'b0, 8'd2, 4'h0); tick(); check_pop();

    // Reset while the combo is being checked clears outputs at once.
    hex_combo = 4'h0; submit = 1'b1; tick(); submit = 1'b0;
    Reset = 1'b1; #1;
    push_exp("t5_async", 4'b0000, 4'b0000, 1'b0, 8'd0, 4'h0); check_pop();
    tick();
    push_exp("t5_held", 4'b0000, 4'b0000, 1'b0, 8'd0, 4'h0); check_pop();
    Reset = 1'b0;

    // Skip rotation across all four rooms.
    target_combos = 16'h4321; req = 4'b1111;
    push_exp("t6_first", 4'b0001, 4'b0000, 1'b0, 8'd0, 4'h1); tick(); check_pop();
    for (int i = 0; i < 4; i++) begin
      skip = 1'b1;
      push_exp("t6_idle", 4'b0000, 4'b0000, 1'b0, 8'd0, 4'h0); tick(); skip = 1'b0; check_pop();
      push_exp("t6_rot", rot_grant[i], 4'b0000, 1'b0, 8'd0, rot_combo[i]); tick(); check_pop();
    end

    // Granted room drops its request.
    req = 4'b1110;
    push_exp("t6_drop", 4'b0000, 4'b0000, 1'b0, 8'd0, 4'h0); tick(); check_pop();
    push_exp("t6_after", 4'b0010, 4'b0000, 1'b0, 8'd0, 4'h2); tick(); check_pop();

    // Saturation of the miss counter.
    hex_combo = 4'h9;
    for (int i = 0; i < 255; i++) begin
      submit = 1'b1; tick(); submit = 1'b0; tick();
      if (i == 0) begin
        push_exp("t7_first", 4'b0010, 4'b0000, 1'b1, 8'd1, 4'h2); check_pop();
      end
      if (i == 254) begin
        push_exp("t7_255", 4'b0010, 4'b0000, 1'b1, 8'd255, 4'h2); check_pop();
      end
`ifdef NEXYS_STARSHIP_REPAIR_LOCKOUT_EN
      repeat (8) tick();
`endif
    end
    submit = 1'b1; tick(); submit = 1'b0;
    push_exp("t7_sat", 4'b0010, 4'b0000, 1'b1, 8'd255, 4'h2); tick(); check_pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
